// File: rtl/lsu.sv
// Load/store unit: one request per handshake, a single-cycle memory strobe
// with optional wait states, and the loaded word aligned and extended.
module lsu #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wen,
    input  logic [2:0]  in_funct3,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_rdata,
    output logic        out_err,
    output logic        men,
    output logic        mwen,
    output logic [63:0] raddr,
    output logic [63:0] waddr,
    output logic [63:0] wdata,
    output logic [7:0]  wmask,
    input  logic [63:0] rdata
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

    logic             wen_q;
    logic [2:0]       funct3_q;
    logic [2:0]       off_q;
    logic [7:0]       mask_q;

    logic             accept_c;
    logic             req_err_c;
    logic [7:0]       mask_c;
    logic [63:0]      wdata_c;
    logic             wen_nx;
    logic [7:0]       mask_nx;
    logic [63:0]      shifted_c;
    logic [63:0]      load_c;

    // Request decode: legality, alignment, lane mask and shifted store data.
    always_comb begin
        accept_c  = in_valid && (state == ST_IDLE);
        req_err_c = 1'b0;
        if (in_wen) begin
            if (in_funct3[2]) req_err_c = 1'b1;
        end else begin
            if (in_funct3 == 3'b111) req_err_c = 1'b1;
        end
        case (in_funct3[1:0])
            2'b01:   if (in_addr[0])          req_err_c = 1'b1;
            2'b10:   if (in_addr[1:0] != 2'b00) req_err_c = 1'b1;
            2'b11:   if (in_addr[2:0] != 3'b000) req_err_c = 1'b1;
            default: ;
        endcase
        case (in_funct3[1:0])
            2'b00:   mask_c = 8'h01;
            2'b01:   mask_c = 8'h03;
            2'b10:   mask_c = 8'h0F;
            default: mask_c = 8'hFF;
        endcase
        mask_c  = mask_c << in_addr[2:0];
        wdata_c = in_wdata << {in_addr[2:0], 3'b000};
    end

    // Load data path: move the addressed lane to bit 0, then extend by size.
    always_comb begin
        shifted_c = rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_c = {{56{shifted_c[7]}},  shifted_c[7:0]};
            3'b001:  load_c = {{48{shifted_c[15]}}, shifted_c[15:0]};
            3'b010:  load_c = {{32{shifted_c[31]}}, shifted_c[31:0]};
            3'b100:  load_c = {56'b0, shifted_c[7:0]};
            3'b101:  load_c = {48'b0, shifted_c[15:0]};
            3'b110:  load_c = {32'b0, shifted_c[31:0]};
            default: load_c = shifted_c;
        endcase
    end

    // State and wait-counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic; wen/mask "next" values let strobes register from state_nx.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wen_nx   = accept_c ? in_wen : wen_q;
        mask_nx  = accept_c ? mask_c : mask_q;
        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    if (req_err_c) begin
                        state_nx = ST_DONE;
                    end else if (WAIT_CYCLES > 0) begin
                        state_nx = ST_WAIT;
                        cnt_nx   = CNT_LOAD;
                    end else begin
                        state_nx = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) state_nx = ST_ACCESS;
                else           cnt_nx   = cnt - CNT_W'(1);
            end
            ST_ACCESS: state_nx = ST_DONE;
            ST_DONE:   if (out_ready) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Registered port outputs and latched request fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            men       <= 1'b0;
            mwen      <= 1'b0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_rdata <= '0;
            raddr     <= '0;
            waddr     <= '0;
            wdata     <= '0;
            wmask     <= '0;
            wen_q     <= 1'b0;
            funct3_q  <= '0;
            off_q     <= '0;
            mask_q    <= '0;
        end else begin
            in_ready  <= (state_nx == ST_IDLE);
            men       <= (state_nx == ST_ACCESS);
            mwen      <= (state_nx == ST_ACCESS) && wen_nx;
            out_valid <= (state_nx == ST_DONE);
            wmask     <= ((state_nx == ST_ACCESS) && wen_nx) ? mask_nx : 8'h00;
            if (accept_c) begin
                wen_q     <= in_wen;
                funct3_q  <= in_funct3;
                off_q     <= in_addr[2:0];
                mask_q    <= mask_c;
                raddr     <= {in_addr[63:3], 3'b000};
                waddr     <= {in_addr[63:3], 3'b000};
                wdata     <= wdata_c;
                out_err   <= req_err_c;
                out_rdata <= '0;
            end
            if ((state == ST_ACCESS) && !wen_q) begin
                out_rdata <= load_c;
            end
        end
    end

endmodule
